// File: rtl/rs_latch_pkg.sv
// Shared types for the gated RS latch array: per-bit state encoding and
// the race-resolution policy selector.
package rs_latch_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SET    = 2'd1,
        ST_FORBID = 2'd2
    } rs_state_e;

    localparam int RACE_RESET = 0;
    localparam int RACE_SET   = 1;
    localparam int RACE_HOLD  = 2;

    // State taken when a forbidden condition is released by both inputs at once.
    function automatic rs_state_e race_target(input int pol, input logic last_q);
        case (pol)
            RACE_SET:  return ST_SET;
            RACE_HOLD: return last_q ? ST_SET : ST_RESET;
            default:   return ST_RESET;
        endcase
    endfunction

endpackage

// File: rtl/rs_latch_cell.sv
// One gated RS latch bit with forbidden-state tracking and race pulse.
// Optional 2-flop input synchronizer when RSLATCH_GATED_SYNC_EN is defined.
//
// state     | meaning
// ST_RESET  | Q=0, Q_L=1
// ST_SET    | Q=1, Q_L=0
// ST_FORBID | S=R=1 seen with E=1; Q=0, Q_L=0, forbidden=1
module rs_latch_cell
    import rs_latch_pkg::*;
#(
    parameter int RACE_POL = RACE_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic e,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_l,
    output logic forbidden,
    output logic race_pulse
);

    logic e_i, s_i, r_i;

`ifdef RSLATCH_GATED_SYNC_EN
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] sync1_d, sync2_d;

    always_comb begin
        sync1_d = {e, s, r};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign {e_i, s_i, r_i} = sync2_q;
`else
    assign {e_i, s_i, r_i} = {e, s, r};
`endif

    rs_state_e state_q, state_d;
    logic      last_q, last_d;
    logic      race_q, race_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        race_d  = 1'b0;
        if (state_q == ST_FORBID) begin
            if (e_i && s_i && r_i) begin
                state_d = ST_FORBID;
            end else if (e_i && (s_i ^ r_i)) begin
                state_d = s_i ? ST_SET : ST_RESET;
                last_d  = s_i;
            end else begin
                // Both inputs dropped together: outcome set by the race policy.
                state_d = race_target(RACE_POL, last_q);
                race_d  = 1'b1;
            end
        end else if (e_i) begin
            if (s_i && r_i) begin
                state_d = ST_FORBID;
            end else if (s_i) begin
                state_d = ST_SET;
                last_d  = 1'b1;
            end else if (r_i) begin
                state_d = ST_RESET;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            last_q  <= 1'b0;
            race_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            race_q  <= race_d;
        end
    end

    assign q          = (state_q == ST_SET);
    assign q_l        = (state_q == ST_RESET);
    assign forbidden  = (state_q == ST_FORBID);
    assign race_pulse = race_q;

endmodule

// File: rtl/rs_latch_gated.sv
// W-bit array of independent gated RS latches (see rs_latch_cell).
// Define RSLATCH_GATED_SYNC_EN to synchronize E/S/R inside each bit.
module rs_latch_gated
    import rs_latch_pkg::*;
#(
    parameter int W        = 1,
    parameter int RACE_POL = RACE_HOLD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] E,
    input  logic [W-1:0] S,
    input  logic [W-1:0] R,
    output logic [W-1:0] Q,
    output logic [W-1:0] Q_L,
    output logic [W-1:0] forbidden,
    output logic [W-1:0] race_pulse
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        rs_latch_cell #(
            .RACE_POL(RACE_POL)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .e          (E[i]),
            .s          (S[i]),
            .r          (R[i]),
            .q          (Q[i]),
            .q_l        (Q_L[i]),
            .forbidden  (forbidden[i]),
            .race_pulse (race_pulse[i])
        );
    end

endmodule

// File: tb/tb_rs_latch_gated.sv
// Self-checking bench for rs_latch_gated: vector table through a latency-aware
// scoreboard, plus async-reset and latency sequences.
module tb_rs_latch_gated;

`ifdef RSLATCH_GATED_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] E = '0, S = '0, R = '0;
    logic [3:0] Q, Q_L, forb, rp;
    logic       q0, ql0, f0, rp0;
    logic       q1, ql1, f1, rp1;

    always #5 clk = ~clk;

    rs_latch_gated #(.W(4), .RACE_POL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .E(E), .S(S), .R(R),
        .Q(Q), .Q_L(Q_L), .forbidden(forb), .race_pulse(rp));
    rs_latch_gated #(.W(1), .RACE_POL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .E(E[0]), .S(S[0]), .R(R[0]),
        .Q(q0), .Q_L(ql0), .forbidden(f0), .race_pulse(rp0));
    rs_latch_gated #(.W(1), .RACE_POL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .E(E[0]), .S(S[0]), .R(R[0]),
        .Q(q1), .Q_L(ql1), .forbidden(f1), .race_pulse(rp1));

    typedef struct {
        string      name;
        logic [3:0] e, s, r;
        logic [3:0] q, ql, f, rp;
        logic       q0, q1;
    } vec_t;

    typedef struct {
        int   due;
        vec_t v;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(string n, logic [3:0] e, logic [3:0] s, logic [3:0] r,
                                logic [3:0] q, logic [3:0] ql, logic [3:0] f,
                                logic [3:0] rpx, logic xq0, logic xq1);
        vec_t v;
        v.name = n; v.e = e; v.s = s; v.r = r;
        v.q = q; v.ql = ql; v.f = f; v.rp = rpx; v.q0 = xq0; v.q1 = xq1;
        return v;
    endfunction

    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            if (x.due != cyc) begin
                tests++; fails++;
                $display("FAIL %s: late check due %0d at cycle %0d", x.v.name, x.due, cyc);
            end else begin
                chk({x.v.name, ".Q"}, Q, x.v.q);
                chk({x.v.name, ".Q_L"}, Q_L, x.v.ql);
                chk({x.v.name, ".forbidden"}, forb, x.v.f);
                chk({x.v.name, ".race_pulse"}, rp, x.v.rp);
                chk({x.v.name, ".pol0_Q"}, {3'b0, q0}, {3'b0, x.v.q0});
                chk({x.v.name, ".pol1_Q"}, {3'b0, q1}, {3'b0, x.v.q1});
                chk({x.v.name, ".pol0_rp"}, {3'b0, rp0}, {3'b0, x.v.rp[0]});
                chk({x.v.name, ".pol1_rp"}, {3'b0, rp1}, {3'b0, x.v.rp[0]});
            end
        end
    end

    task automatic drive(input vec_t v);
        exp_t x;
        @(negedge clk);
        E = v.e; S = v.s; R = v.r;
        x.due = cyc + LAT;
        x.v   = v;
        sb.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        //            name         E        S        R        Q        Q_L      forb     rp     q0 q1
        vecs.push_back(mk("set0",    4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 1, 1));
        vecs.push_back(mk("hold1",   4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 1, 1));
        vecs.push_back(mk("hold2",   4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 1, 1));
        vecs.push_back(mk("hold3",   4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 1, 1));
        vecs.push_back(mk("rst0",    4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk("forbA",   4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk("exitR",   4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk("set0b",   4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 1, 1));
        vecs.push_back(mk("forbB",   4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk("raceE0",  4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0001, 0, 1));
        vecs.push_back(mk("idle",    4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk("multi",   4'b0101, 4'b1111, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 1, 1));
        vecs.push_back(mk("forbAll", 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0));
        vecs.push_back(mk("relE1",   4'b1111, 4'b0000, 4'b0000, 4'b0101, 4'b1010, 4'b0000, 4'b1111, 0, 1));
        vecs.push_back(mk("set13",   4'b1010, 4'b1010, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk("forb3",   4'b1000, 4'b1000, 4'b1000, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 0, 1));
        vecs.push_back(mk("rel3",    4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 0, 1));
        vecs.push_back(mk("rstAll",  4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset.Q", Q, 4'b0000);
        chk("reset.Q_L", Q_L, 4'b1111);
        chk("reset.forbidden", forb, 4'b0000);
        chk("reset.race_pulse", rp, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) drive(vecs[i]);
        @(negedge clk);
        E = '0; S = '0; R = '0;
        drain();

        // Async reset with bits in SET and one bit forbidden, inputs left forbidden.
        drive(mk("preSet", 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 1));
        drive(mk("preForb", 4'b1000, 4'b1000, 4'b1000, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 1, 1));
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("asyncRst.Q", Q, 4'b0000);
        chk("asyncRst.Q_L", Q_L, 4'b1111);
        chk("asyncRst.forbidden", forb, 4'b0000);
        chk("asyncRst.race_pulse", rp, 4'b0000);
        E = '0; S = '0; R = '0;
        @(posedge clk); #1;
        chk("rstHeld.Q", Q, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            @(posedge clk); #1;
            chk("postRst.race_pulse", rp, 4'b0000);
            chk("postRst.Q_L", Q_L, 4'b1111);
        end

        // Exact input-to-output latency of a single set command.
        @(negedge clk);
        E = 4'b0001; S = 4'b0001; R = 4'b0000;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            chk($sformatf("latency.c%0d", k), {3'b0, Q[0]}, {3'b0, (k == LAT)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_latch_gated.md
Name:
rs_latch_gated

Overview:
- Clock-synchronous, cycle-accurate model of a gated (enable-controlled) RS latch array: W independent bits, each with set, reset and enable, driving true and complemented outputs.
- Used in the sequential-logic lab datapath wherever a level-enabled set/reset storage element is needed without real combinational feedback loops.
- Also models and flags the forbidden S=R=1 condition and the race that follows when it is released.

Parameters:
- W, 1, number of independent latch bits.
- RACE_POL, 2, state after leaving forbidden via simultaneous release: 0 = reset (Q=0), 1 = set (Q=1), 2 = restore last valid Q.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- E  input  W  per-bit gate/enable; S and R are ignored while low.
- S  input  W  per-bit set request.
- R  input  W  per-bit reset request.
- Q  output  W  latch true output, registered.
- Q_L  output  W  latch complement output, registered.
- forbidden  output  W  high while the bit is in the S=R=1 forbidden state.
- race_pulse  output  W  one-cycle pulse on the cycle a forbidden state is resolved by simultaneous release.

Behaviour:
- Reset (rst_n=0, asynchronous): every bit Q=0, Q_L=1, forbidden=0, race_pulse=0, last-valid-Q=0. All outputs are held while reset is asserted.
- Each bit is an independent 3-state FSM: ST_RESET (Q=0, Q_L=1), ST_SET (Q=1, Q_L=0), ST_FORBID (Q=0, Q_L=0, forbidden=1).
- All outputs are driven straight from state registers. Inputs sampled at edge k appear on outputs after edge k (1-cycle latency).
- Transitions from ST_RESET or ST_SET, evaluated at a rising edge:
  - E=0: hold.
  - E=1, S=0, R=0: hold.
  - E=1, S=1, R=0: go to ST_SET.
  - E=1, S=0, R=1: go to ST_RESET.
  - E=1, S=1, R=1: go to ST_FORBID.
- Transitions from ST_FORBID:
  - E=1, S=1, R=1: stay in ST_FORBID.
  - E=1, exactly one of S/R high: go to ST_SET or ST_RESET accordingly; no race_pulse.
  - E=0, or E=1 with S=R=0 (simultaneous release): go to the state selected by RACE_POL, and assert race_pulse for exactly that one cycle.
- Last-valid-Q register: updated whenever the bit enters ST_SET or ST_RESET by a normal set/reset command. It is not updated by race resolution.
- Q_L equals ~Q in every state except ST_FORBID, where both are 0 (NOR-latch convention).
- X or Z on inputs: no special handling required; reset defines all state.
- Reset asserted mid-operation, including in ST_FORBID: immediate return to the reset values; race_pulse is not generated.

Optional Feature:
- Macro RSLATCH_GATED_SYNC_EN.
- Defined: E, S and R each pass through a 2-flop synchronizer (reset to 0) before the FSM. Input-to-output latency becomes 3 cycles. Simultaneous release is judged on the synchronized values.
- Undefined: inputs feed the FSM directly; latency is 1 cycle.

Decomposition:
- Package rs_latch_pkg:
  - state enum {ST_RESET, ST_SET, ST_FORBID};
  - RACE_POL constants RACE_RESET=0, RACE_SET=1, RACE_HOLD=2.
- Sub-module rs_latch_cell: one bit (FSM, last-valid register, race pulse, optional synchronizer), instantiated W times via generate in rs_latch_gated.

Test Plan:
- Reset: rst_n=0 mid-run with bits in SET → Q=0, Q_L=1, forbidden=0 immediately, before any clock edge.
- Set/reset/hold: E=1,S=1,R=0 → Q=1,Q_L=0 next cycle. Then E=0,R=1 for 3 cycles → Q stays 1. Then E=1,S=0,R=1 → Q=0,Q_L=1.
- Forbidden entry and exit: E=1,S=R=1 → Q=0,Q_L=0,forbidden=1. Then S=0,R=1 → ST_RESET, race_pulse never asserts.
- Race resolution, RACE_POL=2, last valid Q=1: enter forbidden, then E=0 → Q=1,Q_L=0, race_pulse high one cycle. Repeat with RACE_POL=0 → Q=0; with RACE_POL=1 → Q=1.
- Multi-bit independence, W=4: E=4'b0101, S=4'b1111, R=0 → Q=4'b0101; other bits unchanged.
- RSLATCH_GATED_SYNC_EN defined: single set command → Q rises exactly 3 cycles after the input change.
